// File: rtl/qbus_arbiter_pkg.sv
// Shared constants for the Q-bus arbiter: FSM state encodings and default timeouts.
package qbus_pkg;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CPU_XFER = 3'd1;
    localparam logic [2:0] S_CPU_END  = 3'd2;
    localparam logic [2:0] S_GRANT    = 3'd3;
    localparam logic [2:0] S_DMA      = 3'd4;

    localparam int unsigned DEF_BUS_TIMEOUT   = 63;
    localparam int unsigned DEF_GRANT_TIMEOUT = 15;

    function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/qbus_arbiter.sv
// Registered Q-bus arbiter: CPU read/write sequencing with RPLY timeout, DMA grant handshake.
// Optional macro ARB_FAIR_EN: guarantees one CPU transaction between consecutive DMA tenures.
module qbus_arbiter
    import qbus_pkg::*;
#(
    parameter int unsigned BUS_TIMEOUT   = DEF_BUS_TIMEOUT,
    parameter int unsigned GRANT_TIMEOUT = DEF_GRANT_TIMEOUT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic ce,
    input  logic dati,
    input  logic dato,
    input  logic b,
    output logic done,
    output logic berror,
    output logic bsync,
    output logic bdin,
    output logic bdout,
    output logic bwtbt,
    output logic bbsy,
    input  logic breply,
    input  logic dmr,
    output logic dmgo,
    input  logic sack,
    output logic dma_active
);

    localparam int unsigned TW = timer_width(BUS_TIMEOUT, GRANT_TIMEOUT);

    logic [2:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic done_q, done_d, berror_q, berror_d;
    logic bsync_q, bsync_d, bdin_q, bdin_d, bdout_q, bdout_d, bwtbt_q, bwtbt_d;
    logic bbsy_q, bbsy_d, dmgo_q, dmgo_d, dma_active_q, dma_active_d;
    logic cpu_first;
`ifdef ARB_FAIR_EN
    logic cpu_owed_q, cpu_owed_d;
`endif

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        done_d       = 1'b0;
        berror_d     = 1'b0;
        bsync_d      = bsync_q;
        bdin_d       = bdin_q;
        bdout_d      = bdout_q;
        bwtbt_d      = bwtbt_q;
        bbsy_d       = bbsy_q;
        dmgo_d       = dmgo_q;
        dma_active_d = dma_active_q;
`ifdef ARB_FAIR_EN
        cpu_owed_d   = cpu_owed_q;
        cpu_first    = cpu_owed_q & (dati | dato);
`else
        cpu_first    = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (dmr && !cpu_first) begin
                    state_d = S_GRANT;
                    dmgo_d  = 1'b1;
                    timer_d = TW'(GRANT_TIMEOUT);
                end else if (dati || dato) begin
                    state_d = S_CPU_XFER;
                    bsync_d = 1'b1;
                    bbsy_d  = 1'b1;
                    bdin_d  = dati;
                    bdout_d = dato & ~dati;
                    bwtbt_d = b;
                    timer_d = TW'(BUS_TIMEOUT);
`ifdef ARB_FAIR_EN
                    cpu_owed_d = 1'b0;
`endif
                end
            end

            S_CPU_XFER: begin
                // Reply and timeout share the same bus teardown; only the pulse differs.
                if (breply || (timer_q == '0)) begin
                    state_d  = S_CPU_END;
                    done_d   = breply;
                    berror_d = ~breply;
                    bsync_d  = 1'b0;
                    bdin_d   = 1'b0;
                    bdout_d  = 1'b0;
                    bwtbt_d  = 1'b0;
                    bbsy_d   = 1'b0;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end

            S_CPU_END: state_d = S_IDLE;

            S_GRANT: begin
                if (sack) begin
                    state_d      = S_DMA;
                    dmgo_d       = 1'b0;
                    bbsy_d       = 1'b1;
                    dma_active_d = 1'b1;
                end else if (!dmr || (timer_q == '0)) begin
                    state_d = S_IDLE;
                    dmgo_d  = 1'b0;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end

            S_DMA: begin
                if (!sack) begin
                    state_d      = S_IDLE;
                    bbsy_d       = 1'b0;
                    dma_active_d = 1'b0;
`ifdef ARB_FAIR_EN
                    cpu_owed_d   = 1'b1;
`endif
                end
            end

            default: begin
                state_d      = S_IDLE;
                bsync_d      = 1'b0;
                bdin_d       = 1'b0;
                bdout_d      = 1'b0;
                bwtbt_d      = 1'b0;
                bbsy_d       = 1'b0;
                dmgo_d       = 1'b0;
                dma_active_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            done_q       <= 1'b0;
            berror_q     <= 1'b0;
            bsync_q      <= 1'b0;
            bdin_q       <= 1'b0;
            bdout_q      <= 1'b0;
            bwtbt_q      <= 1'b0;
            bbsy_q       <= 1'b0;
            dmgo_q       <= 1'b0;
            dma_active_q <= 1'b0;
`ifdef ARB_FAIR_EN
            cpu_owed_q   <= 1'b0;
`endif
        end else if (ce) begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            done_q       <= done_d;
            berror_q     <= berror_d;
            bsync_q      <= bsync_d;
            bdin_q       <= bdin_d;
            bdout_q      <= bdout_d;
            bwtbt_q      <= bwtbt_d;
            bbsy_q       <= bbsy_d;
            dmgo_q       <= dmgo_d;
            dma_active_q <= dma_active_d;
`ifdef ARB_FAIR_EN
            cpu_owed_q   <= cpu_owed_d;
`endif
        end
    end

    assign done       = done_q;
    assign berror     = berror_q;
    assign bsync      = bsync_q;
    assign bdin       = bdin_q;
    assign bdout      = bdout_q;
    assign bwtbt      = bwtbt_q;
    assign bbsy       = bbsy_q;
    assign dmgo       = dmgo_q;
    assign dma_active = dma_active_q;

endmodule

// File: tb/tb_qbus_arbiter.sv
// Scenario bench for qbus_arbiter: per-cycle input plans with expected outputs queued and compared.
module tb_qbus_arbiter;

    logic clk = 1'b0;
    logic reset_n = 1'b0, ce = 1'b0, dati = 1'b0, dato = 1'b0, b = 1'b0;
    logic breply = 1'b0, dmr = 1'b0, sack = 1'b0;
    logic done, berror, bsync, bdin, bdout, bwtbt, bbsy, dmgo, dma_active;

    qbus_arbiter #(.BUS_TIMEOUT(63), .GRANT_TIMEOUT(15)) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce), .dati(dati), .dato(dato), .b(b),
        .done(done), .berror(berror), .bsync(bsync), .bdin(bdin), .bdout(bdout),
        .bwtbt(bwtbt), .bbsy(bbsy), .breply(breply), .dmr(dmr), .dmgo(dmgo),
        .sack(sack), .dma_active(dma_active)
    );

    always #5 clk = ~clk;

    // Input bits: {ce, reset_n, dati, dato, b, breply, dmr, sack}
    localparam logic [7:0] I_CE = 8'h80, I_R = 8'h40, I_RD = 8'h20, I_WR = 8'h10;
    localparam logic [7:0] I_BY = 8'h08, I_RP = 8'h04, I_DR = 8'h02, I_SK = 8'h01;
    localparam logic [7:0] CR = I_CE | I_R;
    // Output bits: {done, berror, bsync, bdin, bdout, bwtbt, bbsy, dmgo, dma_active}
    localparam logic [8:0] O_DN = 9'h100, O_BE = 9'h080, O_SY = 9'h040, O_DI = 9'h020;
    localparam logic [8:0] O_DO = 9'h010, O_WT = 9'h008, O_BS = 9'h004, O_DG = 9'h002;
    localparam logic [8:0] O_DA = 9'h001;
    localparam logic [8:0] XR = O_SY | O_DI | O_BS;
    localparam logic [8:0] XW = O_SY | O_DO | O_BS;
    localparam logic [8:0] XD = O_BS | O_DA;

    typedef struct packed {
        logic [7:0] stim;
        logic [8:0] exp;
    } step_t;

    step_t      plan_q[$];
    logic [8:0] exp_q[$];
    logic [8:0] obs, e;
    step_t      p;
    int unsigned checks = 0, errors = 0;

    assign obs = {done, berror, bsync, bdin, bdout, bwtbt, bbsy, dmgo, dma_active};

    task automatic add(input logic [7:0] s, input logic [8:0] x);
        plan_q.push_back('{stim: s, exp: x});
    endtask

    task automatic apply(input logic [7:0] s);
        {ce, reset_n, dati, dato, b, breply, dmr, sack} = s;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        add(I_RD | I_DR, '0);
        add(I_RD | I_DR, '0);
        add(CR, '0);
        for (int i = 0; plan_q.size() > 0; i++) begin
            p = plan_q.pop_front(); apply(p.stim); exp_q.push_back(p.exp); tick();
            e = exp_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL reset c%0d got=%b exp=%b", i, obs, e); end
        end
    endtask

    task automatic test_xfer(input bit rd, input bit wr, input bit bb, input int unsigned nwait);
        logic [7:0] in_v;
        logic [8:0] xv;
        in_v = CR | (rd ? I_RD : 8'h00) | (wr ? I_WR : 8'h00) | (bb ? I_BY : 8'h00);
        xv   = O_SY | O_BS | (rd ? O_DI : 9'h000) | ((wr && !rd) ? O_DO : 9'h000) | (bb ? O_WT : 9'h000);
        add(in_v, xv);
        for (int unsigned k = 0; k < nwait; k++) add(in_v, xv);
        add(in_v | I_RP, O_DN);
        add(CR, '0);
        add(CR, '0);
        for (int i = 0; plan_q.size() > 0; i++) begin
            p = plan_q.pop_front(); apply(p.stim); exp_q.push_back(p.exp); tick();
            e = exp_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL xfer rd%0d wr%0d b%0d c%0d got=%b exp=%b", rd, wr, bb, i, obs, e); end
        end
    endtask

    task automatic test_timeout();
        for (int k = 0; k < 64; k++) add(CR | I_WR, XW);
        add(CR | I_WR, O_BE);
        add(CR, '0);
        add(CR, '0);
        for (int i = 0; plan_q.size() > 0; i++) begin
            p = plan_q.pop_front(); apply(p.stim); exp_q.push_back(p.exp); tick();
            e = exp_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL timeout c%0d got=%b exp=%b", i, obs, e); end
        end
    endtask

    task automatic test_dma();
        add(CR | I_DR, O_DG);
        add(CR | I_DR, O_DG);
        add(CR | I_DR | I_SK, XD);
        for (int k = 0; k < 9; k++) add(CR | I_SK, XD);
        add(CR, '0);
        add(CR, '0);
        for (int i = 0; plan_q.size() > 0; i++) begin
            p = plan_q.pop_front(); apply(p.stim); exp_q.push_back(p.exp); tick();
            e = exp_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL dma c%0d got=%b exp=%b", i, obs, e); end
        end
    endtask

    task automatic test_reset_mid();
        add(CR | I_RD, XR);
        add(CR | I_RD, XR);
        add(I_CE | I_RD, '0);
        add(CR, '0);
        for (int i = 0; plan_q.size() > 0; i++) begin
            p = plan_q.pop_front(); apply(p.stim); exp_q.push_back(p.exp); tick();
            e = exp_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL reset_mid c%0d got=%b exp=%b", i, obs, e); end
        end
    endtask

    task automatic test_simultaneous();
        add(CR | I_DR | I_RD, O_DG);
        add(CR | I_RD | I_SK, XD);
        add(CR | I_RD | I_SK, XD);
        add(CR | I_RD, '0);
        add(CR | I_RD, XR);
        add(CR | I_RD | I_RP, O_DN);
        add(CR, '0);
        for (int i = 0; plan_q.size() > 0; i++) begin
            p = plan_q.pop_front(); apply(p.stim); exp_q.push_back(p.exp); tick();
            e = exp_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL simultaneous c%0d got=%b exp=%b", i, obs, e); end
        end
    endtask

    task automatic test_mid_dmr();
        add(CR | I_RD, XR);
        add(CR | I_RD | I_DR, XR);
        add(CR | I_RD | I_DR, XR);
        add(CR | I_RD | I_RP | I_DR, O_DN);
        add(CR | I_DR, '0);
        add(CR | I_DR, O_DG);
        add(CR, '0);
        for (int i = 0; plan_q.size() > 0; i++) begin
            p = plan_q.pop_front(); apply(p.stim); exp_q.push_back(p.exp); tick();
            e = exp_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL mid_dmr c%0d got=%b exp=%b", i, obs, e); end
        end
    endtask

    task automatic test_grant_timeout();
        for (int k = 0; k < 16; k++) add(CR | I_DR, O_DG);
        add(CR | I_DR, '0);
        add(CR, '0);
        for (int i = 0; plan_q.size() > 0; i++) begin
            p = plan_q.pop_front(); apply(p.stim); exp_q.push_back(p.exp); tick();
            e = exp_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL grant_timeout c%0d got=%b exp=%b", i, obs, e); end
        end
    endtask

    task automatic test_ce_freeze();
        add(CR | I_RD, XR);
        add(I_R | I_RD | I_RP, XR);
        add(CR | I_RD | I_RP, O_DN);
        add(I_R, O_DN);
        add(I_R, O_DN);
        add(CR, '0);
        add(CR, '0);
        for (int i = 0; plan_q.size() > 0; i++) begin
            p = plan_q.pop_front(); apply(p.stim); exp_q.push_back(p.exp); tick();
            e = exp_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL ce_freeze c%0d got=%b exp=%b", i, obs, e); end
        end
    endtask

    task automatic test_priority();
        add(CR | I_DR, O_DG);
        add(CR | I_DR | I_SK, XD);
        add(CR | I_DR | I_SK | I_WR, XD);
        add(CR | I_DR | I_WR, '0);
`ifdef ARB_FAIR_EN
        add(CR | I_DR | I_WR, XW);
        add(CR | I_DR | I_WR | I_RP, O_DN);
        add(CR | I_DR, '0);
        add(CR | I_DR, O_DG);
        add(CR, '0);
`else
        add(CR | I_DR | I_WR, O_DG);
        add(CR | I_WR, '0);
        add(CR | I_WR, XW);
        add(CR | I_WR | I_RP, O_DN);
        add(CR, '0);
        add(CR, '0);
`endif
        for (int i = 0; plan_q.size() > 0; i++) begin
            p = plan_q.pop_front(); apply(p.stim); exp_q.push_back(p.exp); tick();
            e = exp_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL priority c%0d got=%b exp=%b", i, obs, e); end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_xfer(1'b1, 1'b0, 1'b0, 3);
        test_xfer(1'b0, 1'b1, 1'b1, 1);
        test_xfer(1'b1, 1'b1, 1'b0, 0);
        test_timeout();
        test_dma();
        test_reset_mid();
        test_simultaneous();
        test_mid_dmr();
        test_grant_timeout();
        test_ce_freeze();
        test_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
